// File: rtl/de2i_150_qsys_scan_pkg.sv
// rtl/de2i_150_qsys_scan_pkg.sv - register map, bit positions and entry type for the parameter scanner
package de2i_150_qsys_scan_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLR    = 2'd3;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_IDX_LSB = 4;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] value;
  } scan_entry_t;

endpackage

// File: rtl/de2i_150_qsys_scan_fifo.sv
// rtl/de2i_150_qsys_scan_fifo.sv - change-entry FIFO; a pop frees space for a push in the same cycle
module de2i_150_qsys_scan_fifo
  import de2i_150_qsys_scan_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  scan_entry_t   push_data_i,
  input  logic          pop_i,
  output scan_entry_t   head_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);

  scan_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/de2i_150_qsys_param_scanner.sv
// rtl/de2i_150_qsys_param_scanner.sv - round-robin change monitor for 32-bit parameter ports
// Queues {port, value} on every change and exposes the queue through an Avalon slave with irq.
module de2i_150_qsys_param_scanner
  import de2i_150_qsys_scan_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int SCAN_DIV   = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             address,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  input  logic [32*N_PORTS-1:0]  in_ports,
  output logic                   irq
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int PW = $clog2(N_PORTS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DW-1:0]      div_q, div_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               ovf_q, ovf_d;
  logic               irq_q, irq_d;
  logic [31:0]        readdata_q, readdata_d;
  logic [N_PORTS-1:0] valid_q;
  logic [31:0]        shadow_q [N_PORTS];

  scan_entry_t        head, push_entry;
  logic [CW-1:0]      count;
  logic               empty, full;
  logic               tick, change, pop_fire, push_ok, push;
  logic [31:0]        sample, status;
  logic               unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  assign sample   = in_ports[{ptr_q, 5'd0} +: 32];
  assign tick     = ctrl_q[CTRL_EN] && (div_q == DW'(SCAN_DIV - 1));
  assign change   = tick && (!valid_q[ptr_q] || (sample != shadow_q[ptr_q]));
  assign pop_fire = read && (address == ADDR_DATA) && !empty;
  // Full is judged after a same-cycle pop, so a read can make room for this sample.
  assign push_ok  = !full || pop_fire;
  assign push     = change && push_ok;

  always_comb begin
    push_entry.idx   = 4'(ptr_q);
    push_entry.value = sample;
  end

  de2i_150_qsys_scan_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop_fire),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full)
  );

  always_comb begin
    status                     = '0;
    status[ST_EMPTY]           = empty;
    status[ST_FULL]            = full;
    status[ST_OVF]             = ovf_q;
    status[ST_IDX_LSB +: 4]    = empty ? 4'd0 : head.idx;
    status[ST_CNT_LSB +: 8]    = 8'(count);
  end

  always_comb begin
    div_d      = '0;
    ptr_d      = ptr_q;
    ctrl_d     = ctrl_q;
    ovf_d      = ovf_q;
    readdata_d = readdata_q;
    irq_d      = ctrl_q[CTRL_IRQ_EN] && !empty;

    if (ctrl_q[CTRL_EN]) div_d = tick ? '0 : div_q + DW'(1);
    if (tick) ptr_d = (ptr_q == PW'(N_PORTS - 1)) ? '0 : ptr_q + PW'(1);

    if (write && address == ADDR_CTRL) ctrl_d = writedata[1:0];
    if (write && address == ADDR_CLR)  ovf_d  = 1'b0;
    if (change && !push_ok)            ovf_d  = 1'b1;

    if (read) begin
      case (address)
        ADDR_DATA:   readdata_d = empty ? 32'd0 : head.value;
        ADDR_STATUS: readdata_d = status;
        ADDR_CTRL:   readdata_d = {30'd0, ctrl_q};
        default:     readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      ptr_q      <= '0;
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
      valid_q    <= '0;
      for (int k = 0; k < N_PORTS; k++) shadow_q[k] <= '0;
    end else begin
      div_q      <= div_d;
      ptr_q      <= ptr_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
      // A dropped change leaves the shadow stale so the port re-reports later.
      if (push) begin
        shadow_q[ptr_q] <= sample;
        valid_q[ptr_q]  <= 1'b1;
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
